// File: rtl/csr_timer.sv
// Constant timer beside the CSR file: owns TID/TCFG/TVAL/TICLR, counts down
// from the TCFG reload value and raises timer_int when the count hits zero.
module csr_timer #(
  parameter logic [31:0] TID_INIT  = 32'h0,
  parameter logic [31:0] CNT_RESET = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_we,
  input  logic [13:0] csr_wnum,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  output logic        timer_int,
  output logic [31:0] timer_cnt
);

  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;
  localparam logic [31:0] CNT_STOP  = 32'hFFFF_FFFF;

  logic [31:0] tid_q, tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] cnt_q, cnt_d;
  logic        int_q, int_d;
  logic [31:0] reload;
  logic        tid_we, tcfg_we, ticlr_hit, int_set;

  always_comb begin
    tid_we    = csr_we && (csr_wnum == CSR_TID);
    tcfg_we   = csr_we && (csr_wnum == CSR_TCFG);
    ticlr_hit = csr_we && (csr_wnum == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];

    tid_d  = tid_we  ? ((csr_wmask & csr_wvalue) | (~csr_wmask & tid_q))  : tid_q;
    tcfg_d = tcfg_we ? ((csr_wmask & csr_wvalue) | (~csr_wmask & tcfg_q)) : tcfg_q;
    reload = {tcfg_d[31:2], 2'b00};

    // Without a TCFG write tcfg_d equals tcfg_q; a write with En=0 freezes cnt.
    cnt_d = cnt_q;
    if (tcfg_we && tcfg_d[0])
      cnt_d = reload;
    else if (tcfg_d[0] && (cnt_q != CNT_STOP))
      cnt_d = ((cnt_q == 32'h0) && tcfg_d[1]) ? reload : cnt_q - 32'h1;

    // Set uses the registered state and beats a same-cycle clear.
    int_set = tcfg_q[0] && (cnt_q == 32'h0);
    if (int_set)
      int_d = 1'b1;
    else if (ticlr_hit)
      int_d = 1'b0;
    else
      int_d = int_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tid_q  <= TID_INIT;
      tcfg_q <= 32'h0;
      cnt_q  <= CNT_RESET;
      int_q  <= 1'b0;
    end else begin
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      cnt_q  <= cnt_d;
      int_q  <= int_d;
    end
  end

  always_comb begin
    case (csr_rnum)
      CSR_TID:  csr_rvalue = tid_q;
      CSR_TCFG: csr_rvalue = tcfg_q;
      CSR_TVAL: csr_rvalue = cnt_q;
      default:  csr_rvalue = 32'h0;
    endcase
  end

  assign timer_int = int_q;
  assign timer_cnt = cnt_q;

endmodule

// File: tb/tb_csr_timer.sv
// Bench for csr_timer: directed literal checks plus random CSR traffic compared
// every cycle against a model that derives the count from time since arming.
module tb_csr_timer;

  localparam logic [31:0] TID_INIT = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        csr_we = 1'b0;
  logic [13:0] csr_wnum = '0;
  logic [31:0] csr_wmask = '0;
  logic [31:0] csr_wvalue = '0;
  logic [13:0] csr_rnum = '0;
  logic [31:0] csr_rvalue;
  logic        timer_int;
  logic [31:0] timer_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  csr_timer #(.TID_INIT(TID_INIT), .CNT_RESET(32'hFFFF_FFFF)) dut (
    .clk(clk), .resetn(resetn), .csr_we(csr_we), .csr_wnum(csr_wnum),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rnum(csr_rnum),
    .csr_rvalue(csr_rvalue), .timer_int(timer_int), .timer_cnt(timer_cnt)
  );

  always #5 clk = ~clk;

  // Model: while enabled the count is a closed-form function of edges since arming.
  logic [31:0] m_tid, m_tcfg, m_frozen;
  logic        m_int;
  longint      cyc, m_arm;

  function automatic logic [31:0] cnt_now();
    longint r, d;
    if (!m_tcfg[0]) return m_frozen;
    r = longint'({32'd0, m_tcfg[31:2], 2'b00});
    d = cyc - m_arm;
    if (m_tcfg[1]) return 32'(r - (d % (r + 1)));
    return (d <= r) ? 32'(r - d) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model_read(logic [13:0] num);
    case (num)
      14'h40:  return m_tid;
      14'h41:  return m_tcfg;
      14'h42:  return cnt_now();
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin : model
    logic [31:0] cur, nt;
    if (!resetn) begin
      m_tid    <= TID_INIT;
      m_tcfg   <= 32'h0;
      m_frozen <= 32'hFFFF_FFFF;
      m_int    <= 1'b0;
      cyc      <= 0;
      m_arm    <= 0;
    end else begin
      cur = cnt_now();
      if (m_tcfg[0] && cur == 32'h0) m_int <= 1'b1;
      else if (csr_we && csr_wnum == 14'h44 && csr_wmask[0] && csr_wvalue[0]) m_int <= 1'b0;
      cyc <= cyc + 1;
      if (csr_we && csr_wnum == 14'h40)
        m_tid <= (csr_wmask & csr_wvalue) | (~csr_wmask & m_tid);
      if (csr_we && csr_wnum == 14'h41) begin
        nt = (csr_wmask & csr_wvalue) | (~csr_wmask & m_tcfg);
        if (nt[0]) m_arm <= cyc + 1;
        else m_frozen <= cur;
        m_tcfg <= nt;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_int", {31'd0, timer_int}, {31'd0, m_int});
      chk("model_cnt", timer_cnt, cnt_now());
      chk("model_rd", csr_rvalue, model_read(csr_rnum));
    end
  end

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we = 1'b1; csr_wnum = num; csr_wmask = mask; csr_wvalue = val;
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input string nm, input logic [13:0] num, input logic [31:0] exp);
    csr_rnum = num; #1;
    chk(nm, csr_rvalue, exp);
  endtask

  initial begin
    // Reset asserted between edges, observed before any edge.
    #3 resetn = 1'b0;
    #1;
    chk("rst_int", {31'd0, timer_int}, 32'd0);
    chk("rst_cnt", timer_cnt, 32'hFFFF_FFFF);
    rd("rst_tcfg", 14'h41, 32'h0);
    rd("rst_tid", 14'h40, TID_INIT);
    rd("rst_tval", 14'h42, 32'hFFFF_FFFF);
    @(posedge clk); #3 resetn = 1'b1;
    chk_on = 1'b1;
    idle(1);
    wr(14'h40, 32'hFFFF_FFFF, 32'h0);

    // One-shot, R = 20
    wr(14'h41, 32'hFFFF_FFFF, 32'h15);
    chk("os_load", timer_cnt, 32'd20);
    idle(20);
    chk("os_zero", timer_cnt, 32'd0);
    chk("os_int_lo", {31'd0, timer_int}, 32'd0);
    idle(1);
    chk("os_int_hi", {31'd0, timer_int}, 32'd1);
    chk("os_stop", timer_cnt, 32'hFFFF_FFFF);
    idle(5);
    chk("os_frozen", timer_cnt, 32'hFFFF_FFFF);
    chk("os_int_held", {31'd0, timer_int}, 32'd1);
    wr(14'h44, 32'h1, 32'h1);
    chk("os_clr", {31'd0, timer_int}, 32'd0);

    // Periodic, R = 8
    wr(14'h41, 32'hFFFF_FFFF, 32'h0B);
    chk("per_load", timer_cnt, 32'd8);
    idle(8);
    chk("per_zero", timer_cnt, 32'd0);
    chk("per_int_lo", {31'd0, timer_int}, 32'd0);
    idle(1);
    chk("per_int_hi", {31'd0, timer_int}, 32'd1);
    chk("per_reload", timer_cnt, 32'd8);
    wr(14'h44, 32'h1, 32'h1);
    chk("per_clr", {31'd0, timer_int}, 32'd0);
    chk("per_cnt7", timer_cnt, 32'd7);
    idle(7);
    chk("per_zero2", timer_cnt, 32'd0);
    chk("per_int_lo2", {31'd0, timer_int}, 32'd0);
    idle(1);
    chk("per_int_hi2", {31'd0, timer_int}, 32'd1);

    // Periodic R = 0: set beats clear every cycle
    wr(14'h41, 32'hFFFF_FFFF, 32'h3);
    chk("r0_cnt", timer_cnt, 32'd0);
    idle(1);
    chk("r0_int", {31'd0, timer_int}, 32'd1);
    wr(14'h44, 32'h1, 32'h1);
    chk("r0_collide1", {31'd0, timer_int}, 32'd1);
    wr(14'h44, 32'h1, 32'h1);
    chk("r0_collide2", {31'd0, timer_int}, 32'd1);
    chk("r0_cnt_hold", timer_cnt, 32'd0);

    // Masked writes, read-only TVAL
    wr(14'h41, 32'hFFFF_FFFF, 32'h15);
    idle(3);
    chk("mk_run", timer_cnt, 32'd17);
    wr(14'h41, 32'h1, 32'h0);
    chk("mk_hold", timer_cnt, 32'd17);
    rd("mk_tcfg", 14'h41, 32'h14);
    idle(3);
    chk("mk_frozen", timer_cnt, 32'd17);
    wr(14'h42, 32'hFFFF_FFFF, 32'h1234);
    rd("mk_tval_ro", 14'h42, 32'd17);
    wr(14'h40, 32'hFF00, 32'hABCD);
    rd("mk_tid", 14'h40, 32'h0000_AB00);

    // Read decode while running
    wr(14'h41, 32'hFFFF_FFFF, 32'h15);
    rd("dec_00", 14'h00, 32'h0);
    rd("dec_43", 14'h43, 32'h0);
    rd("dec_45", 14'h45, 32'h0);
    rd("dec_44", 14'h44, 32'h0);
    rd("dec_tval", 14'h42, 32'd20);
    wr(14'h44, 32'h1, 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 resetn = 1'b0;
        @(posedge clk); #3 resetn = 1'b1;
      end
      csr_we = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 5))
        0: csr_wnum = 14'h40;
        1, 2: csr_wnum = 14'h41;
        3: csr_wnum = 14'h42;
        4: csr_wnum = 14'h44;
        default: csr_wnum = 14'($urandom());
      endcase
      csr_wmask  = ($urandom_range(0, 9) < 7) ? 32'hFFFF_FFFF : $urandom();
      csr_wvalue = (csr_wnum == 14'h41)
                 ? {28'd0, 4'($urandom_range(0, 12)), 2'b00} | {30'd0, 2'($urandom())}
                 : $urandom();
      case ($urandom_range(0, 7))
        0: csr_rnum = 14'h40;
        1: csr_rnum = 14'h41;
        2, 3: csr_rnum = 14'h42;
        4: csr_rnum = 14'h44;
        5: csr_rnum = 14'h43;
        6: csr_rnum = 14'h45;
        default: csr_rnum = 14'($urandom());
      endcase
      @(posedge clk); #1;
    end
    csr_we = 1'b0;
    idle(2);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
